fast_scanner: RTL and testbench

FAST_SCANNER -- requirements
Module: fast_scanner

---
 rtl/fast_scanner_if.sv | 28 ++
 rtl/fast_scanner.sv | 146 ++++++++++++++
 tb/tb_fast_scanner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fast_scanner_if.sv
// Handshake and status bundle between the FAST scan sequencer and its neighbours.
// The slave modport is the scanner side; the master modport is the driving side.
interface fast_scanner_if;
    logic        start;
    logic        corner_in;
    logic        corner_ready;
    logic [15:0] input_addr;
    logic        FAST_En;
    logic        busy;
    logic        done;
    logic        corner_valid;
    logic [7:0]  corner_x;
    logic [6:0]  corner_y;
    logic [15:0] corner_count;
    logic        overflow;

    modport master (
        output start, corner_in, corner_ready,
        input  input_addr, FAST_En, busy, done, corner_valid,
        input  corner_x, corner_y, corner_count, overflow
    );

    modport slave (
        input  start, corner_in, corner_ready,
        output input_addr, FAST_En, busy, done, corner_valid,
        output corner_x, corner_y, corner_count, overflow
    );
endinterface

// File: rtl/fast_scanner.sv
// Frame scan sequencer for a 16-phase FAST corner controller, with NMS corner
// coordinate tracking and a small corner FIFO toward the downstream consumer.
//
// state | meaning
// IDLE  | waiting for start; FIFO still drains
// RUN   | issuing addresses, 16 enabled cycles per address
// DONE  | one-cycle end-of-frame pulse
module fast_scanner #(
    parameter int WIDTH      = 180,
    parameter int HEIGHT     = 120,
    parameter int NMS_OFFSET = 722,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clock,
    input  logic          nRESET,
    fast_scanner_if.slave bus
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_ADDR = 16'(WIDTH * HEIGHT + NMS_OFFSET - 1);
    localparam logic [15:0] OFFS      = 16'(NMS_OFFSET);
    localparam logic [7:0]  X_MAX     = 8'(WIDTH - 1);
    localparam logic [PW:0] FULL_LVL  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  phase;
    logic [15:0] addr;
    logic [7:0]  ref_x;
    logic [6:0]  ref_y;
    logic        fast_en;
    logic        busy_r;
    logic        done_r;
    logic [15:0] count;
    logic        ovf;

    logic [7:0]  mem_x [FIFO_DEPTH];
    logic [6:0]  mem_y [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fill;

    logic sample, push_req, pop, full, push, drop, valid;

    // corner_in is meaningful only once the NMS window has reached real pixels
    assign sample   = (state == RUN) && (phase == 4'd15) && (addr >= OFFS);
    assign push_req = sample && bus.corner_in;
    assign valid    = (fill != '0);
    assign pop      = valid && bus.corner_ready;
    assign full     = (fill == FULL_LVL);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clock) begin
        if (!nRESET) begin
            state   <= IDLE;
            phase   <= 4'd0;
            addr    <= 16'd0;
            ref_x   <= 8'd0;
            ref_y   <= 7'd0;
            fast_en <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count   <= 16'd0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        phase   <= 4'd0;
                        addr    <= 16'd0;
                        ref_x   <= 8'd0;
                        ref_y   <= 7'd0;
                        count   <= 16'd0;
                        ovf     <= 1'b0;
                        fast_en <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    phase <= phase + 4'd1;
                    if (phase == 4'd15) begin
                        if (addr == LAST_ADDR) begin
                            state   <= DONE;
                            fast_en <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            addr <= addr + 16'd1;
                            if (addr >= OFFS) begin
                                if (ref_x == X_MAX) begin
                                    ref_x <= 8'd0;
                                    ref_y <= ref_y + 7'd1;
                                end else begin
                                    ref_x <= ref_x + 8'd1;
                                end
                            end
                        end
                    end
                    if (push && count != 16'hFFFF) count <= count + 16'd1;
                    if (drop) ovf <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty
    always_ff @(posedge clock) begin
        if (push) begin
            mem_x[wr_ptr] <= ref_x;
            mem_y[wr_ptr] <= ref_y;
        end
    end

    assign bus.input_addr   = addr;
    assign bus.FAST_En      = fast_en;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.corner_valid = valid;
    assign bus.corner_x     = valid ? mem_x[rd_ptr] : 8'd0;
    assign bus.corner_y     = valid ? mem_y[rd_ptr] : 7'd0;
    assign bus.corner_count = count;
    assign bus.overflow     = ovf;
endmodule

// File: tb/tb_fast_scanner.sv
// Directed bench for fast_scanner on an 8x6 frame (NMS offset 18, 4-entry FIFO).
module tb_fast_scanner;
    logic clock = 1'b0;
    logic nRESET;
    int   total = 0;
    int   passed = 0;
    int   en_cnt = 0;
    int   done_cnt = 0;
    int   bad = 0;

    fast_scanner_if bus ();

    fast_scanner #(.WIDTH(8), .HEIGHT(6), .NMS_OFFSET(18), .FIFO_DEPTH(4)) dut (
        .clock (clock),
        .nRESET(nRESET),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.FAST_En === 1'b1) en_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic hit(input int mode, input int k);
        int a = k / 16;
        int p = k % 16;
        case (mode)
            1: return k == 29 * 16 + 15;
            2: return (k == 17 * 16 + 15) || (k == 18 * 16 + 15) || (k == 19 * 16 + 7);
            3: return p == 15 && a >= 18 && a <= 23;
            4: return k == 18 * 16 + 15;
            5: return p == 15 && a >= 18 && a <= 22;
            default: return 1'b0;
        endcase
    endfunction

    // One frame; cycle k of RUN is address k/16, phase k%16. abort_k < 0 runs to the end.
    task automatic scan(input int mode, input int abort_k);
        bad = 0;
        en_cnt = 0;
        done_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 1056; k++) begin
            if (k == abort_k) begin
                bus.corner_in = 1'b0;
                nRESET = 1'b0;
                tick();
                nRESET = 1'b1;
                break;
            end
            if (bus.FAST_En !== 1'b1 || bus.busy !== 1'b1 || bus.input_addr !== 16'(k / 16)) bad++;
            bus.corner_in    = hit(mode, k);
            bus.corner_ready = (mode == 5) && (k == 22 * 16 + 15);
            bus.start        = (mode == 6) && (k == 100);
            tick();
        end
        bus.corner_in    = 1'b0;
        bus.corner_ready = 1'b0;
        bus.start        = 1'b0;
    endtask

    task automatic frame_end(input string tag);
        chk({tag, "_addr_seq_errors"}, bad, 0);
        chk({tag, "_done_hi"}, bus.done, 1);
        chk({tag, "_busy_in_done"}, bus.busy, 1);
        chk({tag, "_en_low_in_done"}, bus.FAST_En, 0);
        tick();
        chk({tag, "_done_lo"}, bus.done, 0);
        chk({tag, "_busy_lo"}, bus.busy, 0);
        chk({tag, "_en_cycles"}, en_cnt, 1056);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic drain(input int n, input int x0, input int y);
        for (int i = 0; i < n; i++) begin
            chk("head_valid", bus.corner_valid, 1);
            chk("head_x", bus.corner_x, x0 + i);
            chk("head_y", bus.corner_y, y);
            bus.corner_ready = 1'b1;
            tick();
            bus.corner_ready = 1'b0;
        end
        chk("drained_valid", bus.corner_valid, 0);
        chk("drained_x", bus.corner_x, 0);
        chk("drained_y", bus.corner_y, 0);
    endtask

    initial begin
        nRESET = 1'b0;
        bus.start = 1'b1;
        bus.corner_in = 1'b0;
        bus.corner_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.FAST_En, 0);
        chk("rst_addr", bus.input_addr, 0);
        chk("rst_valid", bus.corner_valid, 0);
        chk("rst_count", bus.corner_count, 0);
        chk("rst_ovf", bus.overflow, 0);
        bus.start = 1'b0;
        nRESET = 1'b1;
        tick();
        chk("start_in_reset_ignored", bus.busy, 0);

        scan(0, -1);
        frame_end("plain");
        chk("plain_count", bus.corner_count, 0);
        chk("plain_valid", bus.corner_valid, 0);

        scan(1, -1);
        frame_end("single");
        chk("single_count", bus.corner_count, 1);
        tick();
        tick();
        chk("single_held_x", bus.corner_x, 3);
        drain(1, 3, 1);

        scan(2, -1);
        frame_end("window");
        chk("window_count", bus.corner_count, 1);
        drain(1, 0, 0);

        scan(3, -1);
        frame_end("ovf");
        chk("ovf_count", bus.corner_count, 4);
        chk("ovf_flag", bus.overflow, 1);
        scan(0, -1);
        frame_end("after_ovf");
        chk("restart_count", bus.corner_count, 0);
        chk("restart_ovf", bus.overflow, 0);
        drain(4, 0, 0);

        scan(5, -1);
        frame_end("full_pop");
        chk("full_pop_count", bus.corner_count, 5);
        chk("full_pop_ovf", bus.overflow, 0);
        drain(4, 1, 0);

        scan(4, 480);
        chk("abort_addr_seq_errors", bad, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_en", bus.FAST_En, 0);
        chk("abort_addr", bus.input_addr, 0);
        chk("abort_valid", bus.corner_valid, 0);
        chk("abort_x", bus.corner_x, 0);
        chk("abort_count", bus.corner_count, 0);
        chk("abort_ovf", bus.overflow, 0);
        tick();
        tick();
        chk("abort_no_done", done_cnt, 0);
        scan(0, -1);
        frame_end("rescan");

        scan(6, -1);
        frame_end("start_in_run");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
